// File: rtl/pc_step_pkg.sv
// Shared encodings for the PC stepping controller: mode select values and FSM states.
package pc_step_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_BURST  = 2'b10;
    localparam logic [1:0] MODE_RUN_BP = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        RUN   = 2'b10,
        HALT  = 2'b11
    } step_state_t;

endpackage

// File: rtl/push_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, debounced level and
// a one-cycle press pulse on the rising edge of the debounced level.
module push_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            level <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync0 <= push;
            sync1 <= sync0;
            press <= 1'b0;
            if (sync1 != level) begin
                // Level only moves after the synced input has disagreed for the full window
                if (cnt == CNT_MAX) begin
                    level <= sync1;
                    press <= sync1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/pc_step_ctrl.sv
// PC stepping controller: gates CPU advance (step_en) from a debounced push-button in
// manual, free-run, burst and run-to-breakpoint modes, and latches the stepped PC.
//
// state | meaning
// IDLE  | waiting; AUTO steps every cycle here, MANUAL/BURST/RUN_BP wait for a press
// BURST | stepping every cycle until the captured burst length is used up
// RUN   | stepping every cycle until the breakpoint matches
// HALT  | stopped on breakpoint, bp_hit set; a press resumes past the breakpoint
module pc_step_ctrl
    import pc_step_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pcin,
    input  logic [1:0]       mode,
    input  logic             push,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [WIDTH-1:0] bp_addr,
    input  logic             bp_en,
    output logic [WIDTH-1:0] pcout,
    output logic             step_en,
    output logic             bp_hit,
    output logic             busy
);

    step_state_t      state, state_n;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] remaining, remaining_n;
    logic [CNT_W-1:0] eff_len;
    logic [WIDTH-1:0] pcout_n;
    logic             step_n;
    logic             bp_hit_n;
    logic             skip_bp, skip_bp_n;
    logic             press;
    logic             level_unused;

    push_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_push_debounce (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .level(level_unused),
        .press(press)
    );

    assign eff_len = (burst_len == '0) ? CNT_W'(1) : burst_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mode_q    <= MODE_MANUAL;
            remaining <= '0;
            pcout     <= '0;
            step_en   <= 1'b0;
            bp_hit    <= 1'b0;
            skip_bp   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            mode_q    <= mode;
            remaining <= remaining_n;
            pcout     <= pcout_n;
            step_en   <= step_n;
            bp_hit    <= bp_hit_n;
            skip_bp   <= skip_bp_n;
            busy      <= (state_n == BURST) || (state_n == RUN);
        end
    end

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        pcout_n     = pcout;
        step_n      = 1'b0;
        bp_hit_n    = bp_hit;
        skip_bp_n   = skip_bp;

        if (mode != mode_q) begin
            // Any mode change abandons whatever was in progress, including a coincident press
            state_n     = IDLE;
            remaining_n = '0;
            bp_hit_n    = 1'b0;
            skip_bp_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    case (mode)
                        MODE_MANUAL: begin
                            if (press) begin
                                pcout_n = pcin;
                                step_n  = 1'b1;
                            end
                        end
                        MODE_AUTO: begin
                            pcout_n = pcin;
                            step_n  = 1'b1;
                        end
                        MODE_BURST: begin
                            if (press) begin
                                pcout_n = pcin;
                                step_n  = 1'b1;
                                if (eff_len != CNT_W'(1)) begin
                                    state_n     = BURST;
                                    remaining_n = eff_len - 1'b1;
                                end
                            end
                        end
                        default: begin
                            if (press) begin
                                pcout_n   = pcin;
                                step_n    = 1'b1;
                                state_n   = RUN;
                                skip_bp_n = 1'b0;
                            end
                        end
                    endcase
                end
                BURST: begin
                    pcout_n     = pcin;
                    step_n      = 1'b1;
                    remaining_n = remaining - 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        state_n = IDLE;
                    end
                end
                RUN: begin
                    if (bp_en && (pcin == bp_addr) && !skip_bp) begin
                        state_n  = HALT;
                        pcout_n  = pcin;
                        bp_hit_n = 1'b1;
                    end else begin
                        pcout_n = pcin;
                        step_n  = 1'b1;
                    end
                    skip_bp_n = 1'b0;
                end
                default: begin
                    // Resume arms a one-cycle skip so the halted PC can be stepped over
                    if (press) begin
                        state_n   = RUN;
                        bp_hit_n  = 1'b0;
                        skip_bp_n = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_step_ctrl.sv
// Self-checking bench for pc_step_ctrl with a short debounce window and randomized PCs.
module tb_pc_step_ctrl;

    localparam int WIDTH = 32;
    localparam int DEB   = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] pcin;
    logic [1:0]       mode;
    logic             push;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] bp_addr;
    logic             bp_en;
    logic [WIDTH-1:0] pcout;
    logic             step_en;
    logic             bp_hit;
    logic             busy;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] pc_prev;

    pc_step_ctrl #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pcin     (pcin),
        .mode     (mode),
        .push     (push),
        .burst_len(burst_len),
        .bp_addr  (bp_addr),
        .bp_en    (bp_en),
        .pcout    (pcout),
        .step_en  (step_en),
        .bp_hit   (bp_hit),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // pc_prev holds the pcin value presented at the edge just taken
    task automatic tick();
        pc_prev = pcin;
        @(posedge clk);
        #1;
    endtask

    // Clean push: press pulse is high when this returns, acted on at the next edge
    task automatic do_press(input bit rand_pc);
        push = 1'b1;
        repeat (DEB + 2) begin
            if (rand_pc) pcin = $urandom;
            tick();
        end
        push = 1'b0;
    endtask

    task automatic settle();
        push = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 2'b00; push = 1'b0; pcin = '0;
        burst_len = '0; bp_addr = '0; bp_en = 1'b0;
        repeat (3) tick();
        checks++; if (pcout !== '0)   begin errors++; $display("FAIL reset_pcout got %h exp 0", pcout); end
        checks++; if (step_en !== 1'b0) begin errors++; $display("FAIL reset_step got %b exp 0", step_en); end
        checks++; if (bp_hit !== 1'b0)  begin errors++; $display("FAIL reset_bp_hit got %b exp 0", bp_hit); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_manual();
        int glitch_pulses = 0;
        int pulses = 0;
        int pulse_at = -1;
        logic [WIDTH-1:0] got_pc = '0;
        mode = 2'b00; pcin = 32'h40;
        repeat (2) tick();
        for (int g = 0; g < 3; g++) begin
            push = 1'b1;
            repeat ($urandom_range(1, DEB - 1)) begin tick(); if (step_en) glitch_pulses++; end
            push = 1'b0;
            repeat (4) begin tick(); if (step_en) glitch_pulses++; end
        end
        checks++; if (glitch_pulses != 0) begin errors++; $display("FAIL manual_glitch pulses %0d exp 0", glitch_pulses); end
        push = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (step_en) begin pulses++; pulse_at = k; got_pc = pcout; end
        end
        checks++; if (pulses != 1)       begin errors++; $display("FAIL manual_pulses got %0d exp 1", pulses); end
        checks++; if (pulse_at != DEB + 3) begin errors++; $display("FAIL manual_latency got %0d exp %0d", pulse_at, DEB + 3); end
        checks++; if (got_pc !== 32'h40) begin errors++; $display("FAIL manual_pcout got %h exp 40", got_pc); end
        push = 1'b0;
        pulses = 0;
        repeat (15) begin tick(); if (step_en) pulses++; end
        checks++; if (pulses != 0) begin errors++; $display("FAIL manual_release pulses %0d exp 0", pulses); end
        for (int r = 0; r < 3; r++) begin
            do_press(1'b1);
            pcin = $urandom;
            tick();
            checks++; if (step_en !== 1'b1) begin errors++; $display("FAIL manual_rand_step got %b exp 1", step_en); end
            checks++; if (pcout !== pc_prev) begin errors++; $display("FAIL manual_rand_pc got %h exp %h", pcout, pc_prev); end
            tick();
            checks++; if (step_en !== 1'b0) begin errors++; $display("FAIL manual_rand_single got %b exp 0", step_en); end
            settle();
        end
    endtask

    task automatic test_auto();
        mode = 2'b01; pcin = '0;
        repeat (2) tick();
        for (int i = 0; i < 24; i++) begin
            push = 1'($urandom_range(0, 1));
            tick();
            checks++; if (step_en !== 1'b1) begin errors++; $display("FAIL auto_step cyc %0d got %b exp 1", i, step_en); end
            checks++; if (pcout !== pc_prev) begin errors++; $display("FAIL auto_pc cyc %0d got %h exp %h", i, pcout, pc_prev); end
            pcin = pcin + 32'd4;
        end
        settle();
    endtask

    task automatic test_burst();
        int lens [4];
        int len, eff;
        lens[0] = 5; lens[1] = 0; lens[2] = $urandom_range(2, 12); lens[3] = 20;
        mode = 2'b10;
        repeat (2) tick();
        for (int t = 0; t < 4; t++) begin
            len = lens[t];
            eff = (len == 0) ? 1 : len;
            burst_len = CNT_W'(len);
            do_press(1'b1);
            pcin = $urandom;
            for (int i = 0; i < eff + 4; i++) begin
                tick();
                if (i == 0) burst_len = CNT_W'($urandom);
                if (t == 3 && i == 8) push = 1'b1;
                pcin = $urandom;
                checks++; if (step_en !== (i < eff)) begin errors++; $display("FAIL burst_step len %0d cyc %0d got %b exp %b", len, i, step_en, i < eff); end
                if (i < eff) begin
                    checks++; if (pcout !== pc_prev) begin errors++; $display("FAIL burst_pc len %0d cyc %0d got %h exp %h", len, i, pcout, pc_prev); end
                end
                checks++; if (busy !== (i < eff - 1)) begin errors++; $display("FAIL burst_busy len %0d cyc %0d got %b exp %b", len, i, busy, i < eff - 1); end
            end
            settle();
        end
    endtask

    task automatic test_run_bp();
        bit halted = 1'b0;
        mode = 2'b11; bp_en = 1'b1; pcin = '0;
        bp_addr = WIDTH'($urandom_range(4, 10) * 4);
        repeat (2) tick();
        do_press(1'b0);
        for (int i = 0; i < 40 && !halted; i++) begin
            tick();
            if (pc_prev == bp_addr) begin
                halted = 1'b1;
                checks++; if (step_en !== 1'b0) begin errors++; $display("FAIL run_halt_step got %b exp 0", step_en); end
                checks++; if (pcout !== bp_addr) begin errors++; $display("FAIL run_halt_pc got %h exp %h", pcout, bp_addr); end
                checks++; if (bp_hit !== 1'b1) begin errors++; $display("FAIL run_halt_hit got %b exp 1", bp_hit); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_halt_busy got %b exp 0", busy); end
            end else begin
                checks++; if (step_en !== 1'b1 || pcout !== pc_prev) begin errors++; $display("FAIL run_step pc %h got step %b pcout %h", pc_prev, step_en, pcout); end
            end
            if (step_en) pcin = pcin + 32'd4;
        end
        checks++; if (!halted) begin errors++; $display("FAIL run_halt_timeout halted %b exp 1", halted); end
        repeat (3) tick();
        checks++; if (step_en !== 1'b0 || bp_hit !== 1'b1) begin errors++; $display("FAIL run_halt_hold step %b hit %b exp 0 1", step_en, bp_hit); end
        do_press(1'b0);
        tick();
        checks++; if (step_en !== 1'b0 || bp_hit !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL run_resume step %b hit %b busy %b exp 0 0 1", step_en, bp_hit, busy); end
        tick();
        checks++; if (step_en !== 1'b1 || pcout !== bp_addr) begin errors++; $display("FAIL run_skip step %b pcout %h exp 1 %h", step_en, pcout, bp_addr); end
        if (step_en) pcin = pcin + 32'd4;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (step_en !== 1'b1 || pcout !== pc_prev) begin errors++; $display("FAIL run_after step %b pcout %h exp 1 %h", step_en, pcout, pc_prev); end
            if (step_en) pcin = pcin + 32'd4;
        end
        bp_en = 1'b0;
    endtask

    task automatic test_mode_change();
        logic [WIDTH-1:0] last;
        mode = 2'b10; burst_len = 8'd10;
        repeat (2) tick();
        do_press(1'b1);
        pcin = $urandom;
        tick();
        pcin = $urandom;
        tick();
        last = pc_prev;
        checks++; if (step_en !== 1'b1 || pcout !== last) begin errors++; $display("FAIL mode_burst_step step %b pcout %h exp 1 %h", step_en, pcout, last); end
        mode = 2'b00;
        pcin = $urandom;
        tick();
        checks++; if (step_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mode_abort step %b busy %b exp 0 0", step_en, busy); end
        checks++; if (pcout !== last) begin errors++; $display("FAIL mode_pc_hold got %h exp %h", pcout, last); end
        for (int i = 0; i < 12; i++) begin
            pcin = $urandom;
            tick();
            checks++; if (step_en !== 1'b0 || pcout !== last) begin errors++; $display("FAIL mode_idle step %b pcout %h exp 0 %h", step_en, pcout, last); end
        end
    endtask

    task automatic test_reset_mid_run();
        mode = 2'b11; bp_en = 1'b0;
        repeat (2) tick();
        do_press(1'b1);
        for (int i = 0; i < 5; i++) begin
            pcin = $urandom;
            tick();
            checks++; if (step_en !== 1'b1) begin errors++; $display("FAIL rst_run_step cyc %0d got %b exp 1", i, step_en); end
        end
        reset = 1'b1;
        tick();
        checks++; if (pcout !== '0 || step_en !== 1'b0 || bp_hit !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid pcout %h step %b hit %b busy %b exp all 0", pcout, step_en, bp_hit, busy);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (step_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_idle step %b busy %b exp 0 0", step_en, busy); end
        end
        do_press(1'b1);
        tick();
        checks++; if (step_en !== 1'b1 || busy !== 1'b1 || pcout !== pc_prev) begin
            errors++; $display("FAIL rst_restart step %b busy %b pcout %h exp 1 1 %h", step_en, busy, pcout, pc_prev);
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto();
        test_burst();
        test_run_bp();
        test_mode_change();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
